// File: rtl/video_mono_mode_sequencer.sv
// Mono/tint mode sequencer: applies gfx_mode changes only on a vblank rising edge,
// then holds the picture black for BLANK_FRAMES frames. Optional macro: MONO_AUTOCYCLE_EN.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no change in flight; waits for a stable pending request
// WAIT_VB | request armed; next vblank rise loads gfx_mode
// BLANK   | output forced black; counts frames down to re-enable
module video_mono_mode_sequencer #(
    parameter int unsigned BLANK_FRAMES = 2,
    parameter logic [2:0]  RESET_MODE   = 3'b000,
    parameter int unsigned AUTO_FRAMES  = 300
) (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       vblank,
    input  logic [2:0] osd_mode,
    input  logic       cycle_req,
    output logic [2:0] gfx_mode,
    output logic       blank_out,
    output logic       mode_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_FRAMES);

    if (BLANK_FRAMES > 15 || AUTO_FRAMES == 0) begin : g_param_check
        $error("video_mono_mode_sequencer: BLANK_FRAMES must be 0..15 and AUTO_FRAMES nonzero");
    end

    state_t     state_q, state_d;
    logic [2:0] osd_q, osd_d;
    logic [2:0] target_q, target_d;
    logic [2:0] gfx_d;
    logic       pending_q, pending_d;
    logic       blank_d;
    logic       vblank_q;
    logic [3:0] frame_cnt_q, frame_cnt_d;

    logic vb_rise;
    logic osd_chg;
    logic cyc_hit;
    logic auto_hit;
    logic req_any;

    assign vb_rise = ce_pix & vblank & ~vblank_q;
    assign osd_chg = ce_pix & (osd_mode != osd_q);
    assign cyc_hit = ce_pix & cycle_req & ~osd_chg;
    assign req_any = osd_chg | cyc_hit | auto_hit;

`ifdef MONO_AUTOCYCLE_EN
    localparam int AUTO_W = ($clog2(AUTO_FRAMES + 1) > 9) ? $clog2(AUTO_FRAMES + 1) : 9;
    localparam logic [AUTO_W-1:0] AUTO_LOAD = AUTO_W'(AUTO_FRAMES);

    logic [AUTO_W-1:0] auto_cnt_q;
    logic              auto_tc;

    // Down-counter of vblank rises; terminal count acts as the lowest-priority step request.
    assign auto_tc  = vb_rise & (auto_cnt_q == AUTO_W'(1));
    assign auto_hit = auto_tc & ~osd_chg & ~cyc_hit;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt_q <= AUTO_LOAD;
        end else if (osd_chg || (ce_pix && cycle_req) || auto_tc) begin
            auto_cnt_q <= AUTO_LOAD;
        end else if (vb_rise && auto_cnt_q > AUTO_W'(1)) begin
            auto_cnt_q <= auto_cnt_q - AUTO_W'(1);
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            osd_q       <= RESET_MODE;
            target_q    <= RESET_MODE;
            pending_q   <= 1'b0;
            vblank_q    <= 1'b0;
            frame_cnt_q <= 4'd0;
            gfx_mode    <= RESET_MODE;
            blank_out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            osd_q       <= osd_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            gfx_mode    <= gfx_d;
            blank_out   <= blank_d;
            if (ce_pix) begin
                vblank_q <= vblank;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        osd_d       = osd_q;
        target_d    = target_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        gfx_d       = gfx_mode;
        blank_d     = blank_out;

        if (ce_pix) begin
            case (state_q)
                ST_IDLE: begin
                    // Arm only once the target has settled for a cycle.
                    if (pending_q && !req_any) begin
                        state_d = ST_WAIT_VB;
                    end
                end
                ST_WAIT_VB: begin
                    if (vb_rise) begin
                        gfx_d     = target_q;
                        pending_d = 1'b0;
                        if (BLANK_LOAD != 4'd0) begin
                            blank_d     = 1'b1;
                            frame_cnt_d = BLANK_LOAD;
                            state_d     = ST_BLANK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BLANK: begin
                    if (vb_rise) begin
                        frame_cnt_d = frame_cnt_q - 4'd1;
                        if (frame_cnt_q == 4'd1) begin
                            blank_d = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Capture after the FSM so a same-cycle request re-sets pending.
            if (osd_chg) begin
                target_d  = osd_mode;
                osd_d     = osd_mode;
                pending_d = 1'b1;
            end else if (cyc_hit || auto_hit) begin
                target_d  = target_q + 3'd1;
                pending_d = 1'b1;
            end
        end
    end

    assign mode_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_video_mono_mode_sequencer.sv
// Testbench for video_mono_mode_sequencer: directed and random frames checked
// against a frame-level reference model of the mode/blanking rules.
module tb_video_mono_mode_sequencer;

    localparam int         BF         = 2;
    localparam logic [2:0] RM         = 3'd0;
    localparam int         FRAME_LEN  = 40;
    localparam int         VB_START   = 32;

    logic       clk_vid = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic       vblank;
    logic [2:0] osd_mode;
    logic       cycle_req;
    logic [2:0] gfx_mode;
    logic       blank_out;
    logic       mode_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode / request bookkeeping and frames of blanking left.
    logic [2:0] m_gfx, m_target, m_osd_q;
    bit         m_pending, m_vb_q;
    int         m_blank_left;
    logic [2:0] cur_osd;

    video_mono_mode_sequencer #(
        .BLANK_FRAMES(BF),
        .RESET_MODE  (RM),
        .AUTO_FRAMES (300)
    ) dut (
        .clk_vid  (clk_vid),
        .reset_n  (reset_n),
        .ce_pix   (ce_pix),
        .vblank   (vblank),
        .osd_mode (osd_mode),
        .cycle_req(cycle_req),
        .gfx_mode (gfx_mode),
        .blank_out(blank_out),
        .mode_busy(mode_busy)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gfx        = RM;
        m_target     = RM;
        m_osd_q      = RM;
        m_pending    = 0;
        m_vb_q       = 0;
        m_blank_left = 0;
    endtask

    task automatic check_outputs();
        check_val("gfx_mode", gfx_mode, m_gfx);
        check_val("blank_out", blank_out, (m_blank_left > 0));
    endtask

    // One enabled pixel cycle, optionally preceded by stalled (ce_pix=0) cycles.
    task automatic tick(input logic vb, input logic [2:0] osd, input logic creq);
        int stalls;
        stalls = $urandom_range(0, 1);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk_vid);
            ce_pix    = 1'b0;
            cycle_req = 1'b0;
            @(posedge clk_vid);
            #1 check_outputs();
        end
        @(negedge clk_vid);
        ce_pix    = 1'b1;
        vblank    = vb;
        osd_mode  = osd;
        cycle_req = creq;
        @(posedge clk_vid);
        if (vb && !m_vb_q) begin
            if (m_blank_left > 0) begin
                m_blank_left--;
            end else if (m_pending) begin
                m_gfx        = m_target;
                m_pending    = 0;
                m_blank_left = BF;
            end
        end
        m_vb_q = vb;
        if (osd != m_osd_q) begin
            m_target  = osd;
            m_osd_q   = osd;
            m_pending = 1;
        end else if (creq) begin
            m_target  = m_target + 3'd1;
            m_pending = 1;
        end
        #1 check_outputs();
    endtask

    // One frame; requests land mid-frame, well clear of the vblank rise.
    task automatic run_frame(input int rq_at, input logic [2:0] rq_osd, input logic rq_cyc, input bit rnd);
        logic creq;
        for (int i = 0; i < FRAME_LEN; i++) begin
            creq = 1'b0;
            if (rnd && i >= 5 && i <= 25 && $urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: cur_osd = 3'($urandom);
                    1: creq = 1'b1;
                    default: begin
                        cur_osd = 3'($urandom);
                        creq    = 1'b1;
                    end
                endcase
            end else if (!rnd && i == rq_at) begin
                cur_osd = rq_osd;
                creq    = rq_cyc;
            end
            tick(i >= VB_START, cur_osd, creq);
            if (i == 30) check_val("busy_mid", mode_busy, (m_blank_left > 0) || m_pending);
            if (i == VB_START) check_val("busy_vb", mode_busy, (m_blank_left > 0));
        end
    endtask

    task automatic idle_frames(input int n);
        for (int f = 0; f < n; f++) run_frame(-1, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        ce_pix    = 1'b1;
        vblank    = 1'b0;
        osd_mode  = 3'd0;
        cycle_req = 1'b0;
        cur_osd   = 3'd0;
        model_reset();
        repeat (3) @(posedge clk_vid);
        #1;
        check_val("rst_gfx", gfx_mode, RM);
        check_val("rst_blank", blank_out, 1'b0);
        check_val("rst_busy", mode_busy, 1'b0);
        @(negedge clk_vid);
        reset_n = 1'b1;

        idle_frames(3);
        check_val("quiet_gfx", gfx_mode, 3'd0);

        run_frame(10, 3'd1, 1'b0, 1'b0);
        check_val("first_switch", gfx_mode, 3'd1);
        idle_frames(3);

        run_frame(10, 3'd7, 1'b0, 1'b0);
        idle_frames(3);
        run_frame(10, 3'd7, 1'b1, 1'b0);
        idle_frames(3);
        check_val("wrap", gfx_mode, 3'd0);

        run_frame(10, 3'd2, 1'b0, 1'b0);
        idle_frames(3);
        run_frame(10, 3'd3, 1'b1, 1'b0);
        idle_frames(3);
        check_val("osd_wins", gfx_mode, 3'd3);

        run_frame(10, 3'd1, 1'b0, 1'b0);
        run_frame(10, 3'd5, 1'b0, 1'b0);
        check_val("hold_in_blank", gfx_mode, 3'd1);
        idle_frames(4);
        check_val("after_blank", gfx_mode, 3'd5);

        for (int f = 0; f < 40; f++) run_frame(-1, 3'd0, 1'b0, 1'b1);
        idle_frames(3);

        run_frame(10, 3'd6, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick(1'b0, cur_osd, 1'b0);
        check_val("pre_rst_blank", blank_out, 1'b1);
        @(negedge clk_vid);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_gfx", gfx_mode, RM);
        check_val("async_blank", blank_out, 1'b0);
        check_val("async_busy", mode_busy, 1'b0);
        model_reset();
        vblank = 1'b0;
        repeat (2) @(posedge clk_vid);
        @(negedge clk_vid);
        reset_n = 1'b1;
        idle_frames(4);
        check_val("post_rst_gfx", gfx_mode, 3'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
